// File: rtl/fma_pkg.sv
// Shared FMA datapath constants and the CPA control state type.
//   FMA_WIDTH  width of the compressor sum/carry vectors
//   CPA_SEG_W  bits the carry-propagate adder resolves per cycle
//   CPA_NSEG   number of segments (cycles) needed to resolve a full vector
package fma_pkg;

  localparam int FMA_WIDTH = 48;
  localparam int CPA_SEG_W = 12;
  localparam int CPA_NSEG  = FMA_WIDTH / CPA_SEG_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } cpa_state_e;

endpackage

// File: rtl/cpa_segment.sv
// Combinational SEG_W-bit ripple segment of the carry-propagate adder.
//   a, b  : segment operands
//   cin   : carry from the previous (lower) segment
//   s     : segment sum
//   cout  : carry into the next (higher) segment
module cpa_segment #(
  parameter int SEG_W = 12
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};

endmodule

// File: rtl/csa_resolve_cpa.sv
// Resolves a carry-save (sum, carry, cout) triple from the FMA 4:2 compressor
// into a binary result = sum + (carry << 1) + (cout << WIDTH), one SEG_W-bit
// segment per cycle through a single shared segment adder.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (accepted only in IDLE)
//   sum_in, carry_in     : compressor vectors (carry bit i weighs 2^(i+1))
//   cout_in              : compressor top carry, weight 2^WIDTH
//   out_valid / out_ready: result handshake (held in DONE until taken)
//   result               : WIDTH+2 bit unsigned sum, cannot wrap
module csa_resolve_cpa
  import fma_pkg::*;
#(
  parameter int WIDTH = FMA_WIDTH,
  parameter int SEG_W = CPA_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  input  logic             cout_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] result
);

  localparam int NSEG = WIDTH / SEG_W;
  localparam int SIW  = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [SIW-1:0] SEG_LAST = SIW'(NSEG - 1);

  cpa_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       t_q, t_d;        // carry_in MSB + cout_in, both weight 2^WIDTH
  logic             carry_q, carry_d;
  logic [SIW-1:0]   seg_idx_q, seg_idx_d;
  logic [WIDTH+1:0] result_q, result_d;

  logic [SEG_W-1:0] seg_a, seg_b, seg_s;
  logic             seg_co;

  // The shared adder sees the slice selected by the segment counter.
  assign seg_a = a_q[seg_idx_q*SEG_W +: SEG_W];
  assign seg_b = b_q[seg_idx_q*SEG_W +: SEG_W];

  cpa_segment #(.SEG_W(SEG_W)) u_seg (
    .a    (seg_a),
    .b    (seg_b),
    .cin  (carry_q),
    .s    (seg_s),
    .cout (seg_co)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    t_d       = t_q;
    carry_d   = carry_q;
    seg_idx_d = seg_idx_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = sum_in;
          // Pre-shift the carry vector; its MSB falls out at weight 2^WIDTH
          // and is folded into the top bits together with cout_in.
          b_d       = {carry_in[WIDTH-2:0], 1'b0};
          t_d       = {1'b0, carry_in[WIDTH-1]} + {1'b0, cout_in};
          carry_d   = 1'b0;
          seg_idx_d = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        result_d[seg_idx_q*SEG_W +: SEG_W] = seg_s;
        carry_d = seg_co;
        if (seg_idx_q == SEG_LAST) begin
          // T <= 2 and final carry <= 1, so the top two bits never wrap.
          result_d[WIDTH+1:WIDTH] = t_q + {1'b0, seg_co};
          state_d = DONE;
        end else begin
          seg_idx_d = seg_idx_q + SIW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      t_q       <= '0;
      carry_q   <= 1'b0;
      seg_idx_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      t_q       <= t_d;
      carry_q   <= carry_d;
      seg_idx_q <= seg_idx_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_csa_resolve_cpa.sv
module tb_csa_resolve_cpa;
  import fma_pkg::*;

  localparam int W    = FMA_WIDTH;
  localparam int NSEG = CPA_NSEG;

  logic           clk, rst_n;
  logic           in_valid, in_ready, cout_in, out_valid, out_ready;
  logic [W-1:0]   sum_in, carry_in;
  logic [W+1:0]   result;

  int n_vec, n_err, cyc, last_acc;

  csa_resolve_cpa u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .carry_in  (carry_in),
    .cout_in   (cout_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Reference: plain integer arithmetic of the three weighted terms.
  function automatic logic [63:0] ref_sum(input logic [W-1:0] s, input logic [W-1:0] c, input logic co);
    return 64'(s) + (64'(c) << 1) + (64'(co) << W);
  endfunction

  task automatic do_op(input logic [W-1:0] s, input logic [W-1:0] c, input logic co,
                       input int hold, input string tag);
    logic [63:0] exp;
    int n;
    exp = ref_sum(s, c, co);
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    out_ready = (hold == 0);
    sum_in = s; carry_in = c; cout_in = co; in_valid = 1'b1;
    @(posedge clk); #1;
    if (last_acc >= 0) chk({tag, "_spacing_ok"}, 64'(cyc - last_acc >= NSEG + 2), 64'd1);
    last_acc = cyc;
    in_valid = 1'b0;
    chk({tag, "_busy_rdy"}, 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      // Garbage on the inputs while busy must be ignored.
      in_valid = 1'($urandom);
      sum_in = rnd_w(); carry_in = rnd_w(); cout_in = 1'($urandom);
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    chk({tag, "_lat"}, 64'(n), 64'(NSEG));
    chk({tag, "_res"}, 64'(result), exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      sum_in = rnd_w(); carry_in = rnd_w();
      @(posedge clk); #1;
      chk({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
      chk({tag, "_hold_res"}, 64'(result), exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_handoff_vld"}, 64'(out_valid), 64'd0);
    chk({tag, "_handoff_rdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int pulses;
    n_vec = 0; n_err = 0; cyc = 0; last_acc = -1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sum_in = '0; carry_in = '0; cout_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(48'h1, 48'h1, 1'b0, 0, "t1");
    do_op(48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, 0, "t2_prop");
    do_op(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1'b1, 0, "t3_max");
    chk("t3_max_const", 64'(result), 64'h3_FFFF_FFFF_FFFD);
    do_op(48'h1, 48'h1, 1'b0, 10, "t4_bp");

    // Reset in the middle of an operation.
    sum_in = 48'h1; carry_in = 48'h1; cout_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("t5_async_vld", 64'(out_valid), 64'd0);
    chk("t5_async_rdy", 64'(in_ready), 64'd1);
    chk("t5_async_res", 64'(result), 64'd0);
    #2 rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) pulses++; end
    chk("t5_no_pulse", 64'(pulses), 64'd0);
    last_acc = -1;
    do_op(48'h5, 48'h3, 1'b0, 0, "t5_post");

    for (int k = 0; k < 40; k++)
      do_op(rnd_w(), rnd_w(), 1'($urandom), (k < 20) ? 0 : int'($urandom_range(0, 3)), "t6_rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1);
  end

endmodule
